fb_arbiter: RTL and testbench
=============================

FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter ADDR_W, default 15, frame-buffer word address width.
REQ-002 Parameter DATA_W, default 12, pixel word width ({r[3:0],g[3:0],b[3:0]}).
REQ-003 Parameter STARVE_LIM, default 8, consecutive denied mask cycles before the mask requester overrides display priority (legal range 1..255).
REQ-004 clk  in  1  single clock for all state; rising-edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 arb_en  in  1  arbitration enable; low blocks all grants.
REQ-007 disp_req  in  1  display scan-out read request.
REQ-008 disp_addr  in  ADDR_W  display read address.
REQ-009 disp_gnt  out  1  display request accepted this cycle.
REQ-010 disp_rvalid  out  1  disp_rdata valid.
REQ-011 disp_rdata  out  DATA_W  display read data.
REQ-012 mask_req  in  1  mask-engine access request.
REQ-013 mask_we  in  1  mask access is a write (1) or read (0).
REQ-014 mask_addr  in  ADDR_W  mask access address.
REQ-015 mask_wdata  in  DATA_W  mask write data.
REQ-016 mask_gnt  out  1  mask request accepted this cycle.
REQ-017 mask_rvalid  out  1  mask_rdata valid.
REQ-018 mask_rdata  out  DATA_W  mask read data.
REQ-019 mem_en, mem_we  out  1 each  single-port frame-buffer enable and write strobe.
REQ-020 mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W, valid one cycle after a read enable.
REQ-021 disp_miss  out  1  one-cycle pulse: display request denied by a starvation override.

Function
REQ-022 Grants SHALL be combinational from current requests and registered state; at most one of disp_gnt/mask_gnt high per cycle.
REQ-023 mask_gnt SHALL = arb_en & mask_req & (~disp_req | wait_cnt >= STARVE_LIM); disp_gnt SHALL = arb_en & disp_req & ~mask_gnt.
REQ-024 A request SHALL be consumed by exactly one grant cycle; requester holds req/addr/we/wdata stable until granted and may keep req high for back-to-back accesses.
REQ-025 mem_en SHALL = disp_gnt | mask_gnt; mem_we = mask_gnt & mask_we; mem_addr/mem_wdata SHALL mux from the granted requester; mem_addr = 0, mem_wdata = 0 when no grant.
REQ-026 Owner register states: IDLE, DISP_RD, MASK_RD; next state DISP_RD on disp_gnt, MASK_RD on mask_gnt & ~mask_we, else IDLE.
REQ-027 disp_rvalid SHALL be high exactly when owner = DISP_RD, mask_rvalid exactly when owner = MASK_RD; read latency grant-to-rvalid = 1 cycle.
REQ-028 disp_rdata and mask_rdata SHALL pass mem_rdata when their rvalid is high, else 0.
REQ-029 wait_cnt (8 bits) SHALL increment, saturating at STARVE_LIM, each cycle mask_req & arb_en & ~mask_gnt; clear to 0 on mask_gnt, on ~mask_req, or on ~arb_en.
REQ-030 disp_miss SHALL pulse combinationally in any cycle where disp_req & mask_gnt & arb_en.
REQ-031 Mask writes SHALL produce no rvalid; a write grant followed by a display grant the next cycle SHALL be legal (no turnaround bubble).
REQ-032 arb_en falling SHALL not cancel an already-issued read: rvalid for a read granted in the previous cycle still asserts.

Reset
REQ-033 rst_n low SHALL asynchronously force owner = IDLE, wait_cnt = 0, disp_rvalid = mask_rvalid = 0, and force disp_gnt, mask_gnt, mem_en, mem_we, disp_miss to 0 regardless of inputs.
REQ-034 Reset asserted with a read in flight SHALL drop that read (no rvalid after release); first grant possible on the first clk edge window after rst_n rises.

Verification
REQ-035 Display only: disp_req=1, addr 0..3 over 4 cycles, mem_rdata=addr+0x100 -> disp_gnt every cycle, disp_rvalid cycles 2..5 with data 0x100..0x103.
REQ-036 Contention, STARVE_LIM=8: disp_req and mask_req (read) held high -> disp_gnt for 8 cycles, 9th cycle mask_gnt=1, disp_miss=1, mask_rvalid next cycle, wait_cnt back to 0, pattern repeats every 9 cycles.
REQ-037 Mask write 0xABC @ 0x0042 with disp_req low -> mem_en=1, mem_we=1, mem_addr=0x0042, mem_wdata=0xABC, no rvalid next cycle.
REQ-038 arb_en=0 with both requests high for 20 cycles -> no grants, wait_cnt stays 0; arb_en=1 -> disp_gnt first.
REQ-039 rst_n pulsed low mid-cycle right after a mask read grant -> mask_rvalid never asserts; all outputs 0 while low.
REQ-040 mask_req dropped after 5 denied cycles then reasserted -> wait_cnt restarts at 0, override only after 8 further denials.

Source files
------------

// File: rtl/fb_arbiter.sv
// Frame-buffer arbiter: shares one single-port memory between display scan-out
// reads and mask-engine reads/writes, with a starvation override for the mask side.
module fb_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 12,
    parameter int STARVE_LIM = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arb_en,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    input  logic              mask_req,
    input  logic              mask_we,
    input  logic [ADDR_W-1:0] mask_addr,
    input  logic [DATA_W-1:0] mask_wdata,
    output logic              mask_gnt,
    output logic              mask_rvalid,
    output logic [DATA_W-1:0] mask_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              disp_miss,
    output logic [1:0]        dbg_owner,
    output logic [7:0]        dbg_wait_cnt
);

    // Handshake: a requester raises req with stable addr/we/wdata and holds them
    // until it sees gnt high in the same cycle; that cycle consumes the request.
    // Read data returns one cycle later, qualified by the matching rvalid.

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DISP_RD = 2'd1,
        MASK_RD = 2'd2
    } owner_t;

    localparam logic [7:0] LIM = 8'(STARVE_LIM);

    owner_t     owner;
    logic [7:0] wait_cnt;
    logic       starved;

    assign starved = (wait_cnt >= LIM);

    // rst_n gates the grants so nothing reaches memory while reset is held.
    always_comb begin
        mask_gnt  = rst_n & arb_en & mask_req & (~disp_req | starved);
        disp_gnt  = rst_n & arb_en & disp_req & ~mask_gnt;
        disp_miss = rst_n & arb_en & disp_req & mask_gnt;
    end

    always_comb begin
        mem_en    = disp_gnt | mask_gnt;
        mem_we    = mask_gnt & mask_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (mask_gnt) begin
            mem_addr  = mask_addr;
            mem_wdata = mask_wdata;
        end else if (disp_gnt) begin
            mem_addr  = disp_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner    <= IDLE;
            wait_cnt <= '0;
        end else begin
            if (disp_gnt)
                owner <= DISP_RD;
            else if (mask_gnt && !mask_we)
                owner <= MASK_RD;
            else
                owner <= IDLE;

            if (mask_gnt || !mask_req || !arb_en)
                wait_cnt <= '0;
            else if (!starved)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    always_comb begin
        disp_rvalid = (owner == DISP_RD);
        mask_rvalid = (owner == MASK_RD);
        disp_rdata  = disp_rvalid ? mem_rdata : '0;
        mask_rdata  = mask_rvalid ? mem_rdata : '0;
    end

    assign dbg_owner    = owner;
    assign dbg_wait_cnt = wait_cnt;

endmodule

// File: tb/tb_fb_arbiter.sv
// Randomised and directed bench for fb_arbiter: a per-cycle reference model
// predicts grants and memory traffic, a scoreboard queue checks returned read data.
module tb_fb_arbiter;

    localparam int ADDR_W     = 15;
    localparam int DATA_W     = 12;
    localparam int STARVE_LIM = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              arb_en;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;
    logic              mask_req;
    logic              mask_we;
    logic [ADDR_W-1:0] mask_addr;
    logic [DATA_W-1:0] mask_wdata;
    logic              mask_gnt;
    logic              mask_rvalid;
    logic [DATA_W-1:0] mask_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              disp_miss;
    logic [1:0]        dbg_owner;
    logic [7:0]        dbg_wait_cnt;

    fb_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIM(STARVE_LIM)) dut (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
        .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .mask_req(mask_req), .mask_we(mask_we), .mask_addr(mask_addr),
        .mask_wdata(mask_wdata), .mask_gnt(mask_gnt), .mask_rvalid(mask_rvalid),
        .mask_rdata(mask_rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .disp_miss(disp_miss), .dbg_owner(dbg_owner), .dbg_wait_cnt(dbg_wait_cnt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- memory behind the arbiter ----------------
    logic [DATA_W-1:0] fake_mem [256];
    logic [DATA_W-1:0] ref_mem  [256];

    always @(posedge clk) begin
        if (mem_en && mem_we)
            fake_mem[mem_addr[7:0]] <= mem_wdata;
        else if (mem_en)
            mem_rdata <= fake_mem[mem_addr[7:0]];
        else
            mem_rdata <= DATA_W'($urandom);
    end

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_disp_q[$];
    logic [DATA_W-1:0] exp_mask_q[$];

    // reference model state
    int m_wait, m_wait_n;
    bit m_prev_d, m_prev_d_n, m_prev_m, m_prev_m_n;
    bit p_dg, p_mg;
    int dut_mgnt_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor: read data against expected queue ----------------
    always @(negedge clk) begin
        if (disp_rvalid) begin
            checks++;
            if (exp_disp_q.size() == 0) begin
                errors++;
                $display("FAIL disp_rdata_unexpected: got 0x%0h expected no read at %0t", disp_rdata, $time);
            end else begin
                logic [DATA_W-1:0] e;
                e = exp_disp_q.pop_front();
                if (disp_rdata !== e) begin
                    errors++;
                    $display("FAIL disp_rdata: got 0x%0h expected 0x%0h at %0t", disp_rdata, e, $time);
                end
            end
        end
        if (mask_rvalid) begin
            checks++;
            if (exp_mask_q.size() == 0) begin
                errors++;
                $display("FAIL mask_rdata_unexpected: got 0x%0h expected no read at %0t", mask_rdata, $time);
            end else begin
                logic [DATA_W-1:0] e;
                e = exp_mask_q.pop_front();
                if (mask_rdata !== e) begin
                    errors++;
                    $display("FAIL mask_rdata: got 0x%0h expected 0x%0h at %0t", mask_rdata, e, $time);
                end
            end
        end
    end

    // ---------------- model evaluation (called at negedge) ----------------
    task automatic eval_cycle();
        bit mg, dg;
        int ea, ed;
        mg = arb_en && mask_req && (!disp_req || m_wait >= STARVE_LIM);
        dg = arb_en && disp_req && !mg;
        ea = mg ? int'(mask_addr) : (dg ? int'(disp_addr) : 0);
        ed = mg ? int'(mask_wdata) : 0;
        if (mask_gnt) dut_mgnt_cnt++;
        chk("disp_gnt", 32'(disp_gnt), 32'(dg));
        chk("mask_gnt", 32'(mask_gnt), 32'(mg));
        chk("disp_miss", 32'(disp_miss), 32'(disp_req && mg));
        chk("mem_en", 32'(mem_en), 32'(dg || mg));
        chk("mem_we", 32'(mem_we), 32'(mg && mask_we));
        chk("mem_addr", 32'(mem_addr), 32'(ea));
        chk("mem_wdata", 32'(mem_wdata), 32'(ed));
        chk("disp_rvalid", 32'(disp_rvalid), 32'(m_prev_d));
        chk("mask_rvalid", 32'(mask_rvalid), 32'(m_prev_m));
        if (!m_prev_d) chk("disp_rdata_idle", 32'(disp_rdata), 32'd0);
        if (!m_prev_m) chk("mask_rdata_idle", 32'(mask_rdata), 32'd0);
        chk("wait_cnt", 32'(dbg_wait_cnt), 32'(m_wait));
        if (dg) exp_disp_q.push_back(ref_mem[disp_addr[7:0]]);
        if (mg && !mask_we) exp_mask_q.push_back(ref_mem[mask_addr[7:0]]);
        if (mg && mask_we) ref_mem[mask_addr[7:0]] = mask_wdata;
        m_prev_d_n = dg;
        m_prev_m_n = mg && !mask_we;
        if (mg || !mask_req || !arb_en) m_wait_n = 0;
        else m_wait_n = (m_wait < STARVE_LIM) ? m_wait + 1 : m_wait;
        p_dg = dg;
        p_mg = mg;
    endtask

    task automatic commit();
        m_wait   = m_wait_n;
        m_prev_d = m_prev_d_n;
        m_prev_m = m_prev_m_n;
    endtask

    task automatic model_reset();
        m_wait   = 0;
        m_prev_d = 0;
        m_prev_m = 0;
        exp_disp_q.delete();
        exp_mask_q.delete();
    endtask

    // ---------------- driver ----------------
    task automatic set_inputs(input bit en, input bit dreq, input int daddr,
                              input bit mreq, input bit mwe, input int maddr, input int wd);
        arb_en     = en;
        disp_req   = dreq;
        disp_addr  = ADDR_W'(daddr);
        mask_req   = mreq;
        mask_we    = mwe;
        mask_addr  = ADDR_W'(maddr);
        mask_wdata = DATA_W'(wd);
    endtask

    task automatic drive_cycle(input bit en, input bit dreq, input int daddr,
                               input bit mreq, input bit mwe, input int maddr, input int wd);
        set_inputs(en, dreq, daddr, mreq, mwe, maddr, wd);
        @(negedge clk);
        eval_cycle();
        @(posedge clk);
        commit();
        #1;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_disp_gnt", 32'(disp_gnt), 32'd0);
        chk("rst_mask_gnt", 32'(mask_gnt), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_disp_miss", 32'(disp_miss), 32'd0);
        chk("rst_disp_rvalid", 32'(disp_rvalid), 32'd0);
        chk("rst_mask_rvalid", 32'(mask_rvalid), 32'd0);
        chk("rst_wait_cnt", 32'(dbg_wait_cnt), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int da;
        bit d_pend, m_pend, m_w;
        int d_a, m_a, m_d;
        for (int i = 0; i < 256; i++) begin
            fake_mem[i] = DATA_W'(i + 'h100);
            ref_mem[i]  = DATA_W'(i + 'h100);
        end
        mem_rdata = '0;
        model_reset();

        // Reset held with every request active: nothing may leak out.
        rst_n = 1'b0;
        set_inputs(1, 1, 3, 1, 1, 4, 'h555);
        @(negedge clk);
        chk_reset_outputs();
        @(negedge clk);
        chk_reset_outputs();
        set_inputs(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Display-only streaming reads, addresses 0..3.
        for (int a = 0; a < 4; a++) drive_cycle(1, 1, a, 0, 0, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 0, 0);

        // Mask write then display read of the same word.
        drive_cycle(1, 0, 0, 1, 1, 'h42, 'hABC);
        drive_cycle(1, 1, 'h42, 0, 0, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 0, 0);

        // Sustained contention: mask read wins once every STARVE_LIM+1 cycles.
        dut_mgnt_cnt = 0;
        da = 16;
        for (int c = 0; c < 3 * (STARVE_LIM + 1); c++) begin
            drive_cycle(1, 1, da, 1, 0, 7, 0);
            if (p_dg) da++;
        end
        chk("contention_mask_grants", 32'(dut_mgnt_cnt), 32'd3);
        drive_cycle(1, 0, 0, 0, 0, 0, 0);

        // Arbitration disabled: no grants, counter held at zero.
        dut_mgnt_cnt = 0;
        for (int c = 0; c < 20; c++) drive_cycle(0, 1, 20, 1, 0, 21, 0);
        drive_cycle(1, 1, 20, 1, 0, 21, 0);
        chk("disabled_mask_grants", 32'(dut_mgnt_cnt), 32'd0);

        // A read granted just before arb_en falls still returns data.
        drive_cycle(1, 0, 0, 1, 0, 21, 0);
        drive_cycle(1, 1, 22, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0, 0, 0);

        // Mask request withdrawn after five denials restarts the starvation count.
        dut_mgnt_cnt = 0;
        for (int c = 0; c < 5; c++) drive_cycle(1, 1, 30 + c, 1, 0, 31, 0);
        drive_cycle(1, 1, 35, 0, 0, 0, 0);
        for (int c = 0; c < STARVE_LIM; c++) drive_cycle(1, 1, 36 + c, 1, 0, 31, 0);
        chk("restart_no_early_override", 32'(dut_mgnt_cnt), 32'd0);
        drive_cycle(1, 1, 50, 1, 0, 31, 0);
        chk("restart_override", 32'(dut_mgnt_cnt), 32'd1);
        drive_cycle(1, 0, 0, 0, 0, 0, 0);

        // Reset asserted mid-cycle right after a mask read grant.
        set_inputs(1, 0, 0, 1, 0, 9, 0);
        @(negedge clk);
        eval_cycle();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        set_inputs(1, 1, 10, 1, 0, 9, 0);
        @(negedge clk);
        chk_reset_outputs();
        @(negedge clk);
        chk_reset_outputs();
        set_inputs(0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive_cycle(1, 0, 0, 0, 0, 0, 0);
        drive_cycle(1, 1, 11, 0, 0, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 0, 0);

        // Random traffic; each requester holds its request until granted.
        d_pend = 0; m_pend = 0; m_w = 0; d_a = 0; m_a = 0; m_d = 0;
        for (int c = 0; c < 300; c++) begin
            if (!d_pend && $urandom_range(0, 3) != 0) begin
                d_pend = 1;
                d_a = $urandom_range(0, 31);
            end
            if (!m_pend && $urandom_range(0, 1) != 0) begin
                m_pend = 1;
                m_w = 1'($urandom_range(0, 1));
                m_a = $urandom_range(0, 31);
                m_d = $urandom_range(0, 4095);
            end
            drive_cycle(1'($urandom_range(0, 9) != 0), d_pend, d_a, m_pend, m_w, m_a, m_d);
            if (p_dg) d_pend = 0;
            if (p_mg) m_pend = 0;
        end
        drive_cycle(1, 0, 0, 0, 0, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 0, 0);

        chk("disp_queue_drained", 32'(exp_disp_q.size()), 32'd0);
        chk("mask_queue_drained", 32'(exp_mask_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
